mmio_host_responder: RTL and testbench

//  Data-bus responder (req/gnt/rvalid) to the core's LSU data port. It implements the host-side

---
 rtl/mmio_host_pkg.sv | 16 +
 rtl/mmio_tx_fifo.sv | 53 +++++
 rtl/mmio_host_responder.sv | 134 +++++++++++++
 tb/tb_mmio_host_responder.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_host_pkg.sv
// Shared constants for the host-side MMIO window: register offsets,
// STATUS bit positions and the default window base address.
package mmio_host_pkg;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h003F_FFF0;

    localparam logic [1:0] OFF_TX     = 2'd0;
    localparam logic [1:0] OFF_CYCLE  = 2'd1;
    localparam logic [1:0] OFF_STATUS = 2'd2;
    localparam logic [1:0] OFF_FINISH = 2'd3;

    localparam int STATUS_FULL_BIT   = 0;
    localparam int STATUS_EMPTY_BIT  = 1;
    localparam int STATUS_FINISH_BIT = 2;

endpackage

// File: rtl/mmio_tx_fifo.sv
// Console TX FIFO: synchronous first-in first-out buffer whose pointers
// carry an extra wrap bit so that full and empty can be told apart.
// The head entry is read straight out of the storage registers.
module mmio_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_pushData,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wrPtr;
    logic [AW:0]      r_rdPtr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_push;
    logic             w_pop;

    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_empty = (r_wrPtr == r_rdPtr);
    assign o_full  = (r_wrPtr[AW] != r_rdPtr[AW]) && (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
    assign o_count = r_wrPtr - r_rdPtr;
    assign o_head  = r_mem[r_rdPtr[AW-1:0]];

    // Storage and pointer update; storage is cleared so the head reads 0 out of reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wrPtr[AW-1:0]] <= i_pushData;
                r_wrPtr                <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mmio_host_responder.sv
// Host MMIO responder on the core data bus: decodes a 16-byte window,
// grants requests combinationally, answers one cycle after each grant,
// and implements the console FIFO, cycle counter, status and finish word.
module mmio_host_responder
    import mmio_host_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = DEFAULT_BASE_ADDR,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        data_req_i,
    input  logic [31:0] data_addr_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        console_valid_o,
    output logic [7:0]  console_data_o,
    input  logic        console_ready_i,
    output logic        finish_o,
    output logic [31:0] exit_code_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          w_hit;
    logic [1:0]    w_off;
    logic          w_txWrite;
    logic          w_gnt;
    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    logic [7:0]    w_head;
    logic          w_cycleLoad;
    logic          w_finishWrite;
    logic [31:0]   w_readData;
    logic [1:0]    w_unusedAddrBits;

    logic          r_rvalid;
    logic [31:0]   r_rdata;
    logic [31:0]   r_cycle;
    logic          r_finish;
    logic [31:0]   r_exitCode;

    assign w_unusedAddrBits = data_addr_i[1:0];

    assign w_hit     = data_req_i && (data_addr_i[31:4] == BASE_ADDR[31:4]);
    assign w_off     = data_addr_i[3:2];
    assign w_txWrite = data_we_i && (w_off == OFF_TX) && data_be_i[0];

    // Full is taken before any same-cycle pop, keeping console_ready_i off the grant path.
    assign w_gnt         = w_hit && !(w_txWrite && w_full);
    assign w_push        = w_gnt && w_txWrite;
    assign w_pop         = console_ready_i && !w_empty;
    assign w_cycleLoad   = w_gnt && data_we_i && (w_off == OFF_CYCLE) && (data_be_i == 4'hF);
    assign w_finishWrite = w_gnt && data_we_i && (w_off == OFF_FINISH) && (data_be_i != 4'h0) && !r_finish;

    mmio_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_txFifo (
        .i_clk      (clk_i),
        .i_rst      (rst_i),
        .i_push     (w_push),
        .i_pushData (data_wdata_i[7:0]),
        .i_pop      (w_pop),
        .o_head     (w_head),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_count    (w_count)
    );

    // Read mux over the register map, reflecting state before this cycle's updates.
    always_comb begin
        w_readData = '0;
        case (w_off)
            OFF_TX:     w_readData = 32'(w_count);
            OFF_CYCLE:  w_readData = r_cycle;
            OFF_STATUS: begin
                w_readData[STATUS_FULL_BIT]   = w_full;
                w_readData[STATUS_EMPTY_BIT]  = w_empty;
                w_readData[STATUS_FINISH_BIT] = r_finish;
            end
            default:    w_readData = r_exitCode;
        endcase
    end

    // Response register: every grant yields rvalid next cycle, writes return zero data.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= w_gnt;
            r_rdata  <= (w_gnt && !data_we_i) ? w_readData : 32'h0;
        end
    end

    // Free-running cycle counter; a full-word write replaces the increment.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cycle <= '0;
        end else if (w_cycleLoad) begin
            r_cycle <= data_wdata_i;
        end else begin
            r_cycle <= r_cycle + 32'd1;
        end
    end

    // Finish latch: only the first FINISH write is kept.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_finish   <= 1'b0;
            r_exitCode <= '0;
        end else if (w_finishWrite) begin
            r_finish   <= 1'b1;
            r_exitCode <= data_wdata_i;
        end
    end

    assign data_gnt_o      = w_gnt;
    assign data_rvalid_o   = r_rvalid;
    assign data_rdata_o    = r_rdata;
    assign console_valid_o = !w_empty;
    assign console_data_o  = w_head;
    assign finish_o        = r_finish;
    assign exit_code_o     = r_exitCode;

endmodule

// File: tb/tb_mmio_host_responder.sv
// Bench for mmio_host_responder: directed scenarios followed by random
// accesses, checked by a scoreboard against a behavioural model of the window.
module tb_mmio_host_responder;

    localparam logic [31:0] BASE  = 32'h003F_FFF0;
    localparam int          DEPTH = 8;

    logic        clk;
    logic        rst;
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        consoleValid;
    logic [7:0]  consoleData;
    logic        consoleReady;
    logic        finish;
    logic [31:0] exitCode;

    mmio_host_responder #(
        .BASE_ADDR  (BASE),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .data_req_i      (req),
        .data_addr_i     (addr),
        .data_we_i       (we),
        .data_be_i       (be),
        .data_wdata_i    (wdata),
        .data_gnt_o      (gnt),
        .data_rvalid_o   (rvalid),
        .data_rdata_o    (rdata),
        .console_valid_o (consoleValid),
        .console_data_o  (consoleData),
        .console_ready_i (consoleReady),
        .finish_o        (finish),
        .exit_code_o     (exitCode)
    );

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        expQ[$];
    logic [7:0]  fifoQ[$];
    logic [31:0] loadBase;
    int          loadEdge;
    int          edgeCount;
    bit          finishM;
    logic [31:0] exitM;
    bit          inReset;
    int          checks;
    int          passes;

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Abort if the run never reaches its summary.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: run did not complete, passed %0d of %0d", passes, checks);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    function automatic void resetModel();
        expQ.delete();
        fifoQ.delete();
        loadBase  = 32'h0;
        loadEdge  = 0;
        edgeCount = 0;
        finishM   = 1'b0;
        exitM     = 32'h0;
    endfunction

    // What a read of the given offset returns given the model's present state.
    function automatic logic [31:0] modelRead(input logic [1:0] off);
        case (off)
            2'd0:    return 32'(fifoQ.size());
            2'd1:    return loadBase + 32'(edgeCount - loadEdge);
            2'd2:    return {29'b0, finishM, fifoQ.size() == 0, fifoQ.size() == DEPTH};
            default: return exitM;
        endcase
    endfunction

    // One bus cycle with the inputs already driven: predict the grant, record the
    // expected response, advance the model across the clock edge.
    task automatic runCycle(output bit granted);
        bit         hit;
        bit         txWrite;
        bit         expGnt;
        bit         popNow;
        logic [1:0] off;
        logic [31:0] rd;
        #1;
        off     = addr[3:2];
        hit     = req && (addr[31:4] == BASE[31:4]);
        txWrite = we && (off == 2'd0) && be[0];
        expGnt  = hit && !(txWrite && fifoQ.size() == DEPTH);
        checkOutput("gnt", {31'b0, gnt}, {31'b0, expGnt});
        popNow = consoleReady && fifoQ.size() > 0;
        if (expGnt) begin
            rd = we ? 32'h0 : modelRead(off);
            expQ.push_back('{rd, edgeCount + 1});
            if (txWrite) fifoQ.push_back(wdata[7:0]);
            if (we && off == 2'd1 && be == 4'hF) begin
                loadBase = wdata;
                loadEdge = edgeCount + 1;
            end
            if (we && off == 2'd3 && be != 4'h0 && !finishM) begin
                finishM = 1'b1;
                exitM   = wdata;
            end
        end
        if (popNow) void'(fifoQ.pop_front());
        granted = expGnt;
        @(posedge clk);
        edgeCount++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bit g;
        req = 1'b0;
        for (int i = 0; i < n; i++) runCycle(g);
    endtask

    // Hold a request until granted, within a cycle budget.
    task automatic applyStimulus(input logic [31:0] a, input logic w, input logic [3:0] b,
                                 input logic [31:0] d, input int maxCycles, input bit forceDrain);
        bit g;
        int n;
        req   = 1'b1;
        addr  = a;
        we    = w;
        be    = b;
        wdata = d;
        g     = 1'b0;
        n     = 0;
        while (!g && n < maxCycles) begin
            if (forceDrain && n >= 4) consoleReady = 1'b1;
            runCycle(g);
            n++;
        end
        if (!g) begin
            checks++;
            $display("[TB] FAIL grant_timeout: addr 0x%08h not granted in %0d cycles", a, maxCycles);
        end
        req = 1'b0;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_gnt"}, {31'b0, gnt}, 32'h0);
        checkOutput({tag, "_rvalid"}, {31'b0, rvalid}, 32'h0);
        checkOutput({tag, "_rdata"}, rdata, 32'h0);
        checkOutput({tag, "_console_valid"}, {31'b0, consoleValid}, 32'h0);
        checkOutput({tag, "_console_data"}, {24'b0, consoleData}, 32'h0);
        checkOutput({tag, "_finish"}, {31'b0, finish}, 32'h0);
        checkOutput({tag, "_exit_code"}, exitCode, 32'h0);
    endtask

    // Monitor: pops the scoreboard on each response and compares observable state.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!inReset) begin
                if (rvalid) begin
                    if (expQ.size() == 0) begin
                        checks++;
                        $display("[TB] FAIL unexpected_rvalid: rdata 0x%08h with nothing outstanding", rdata);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("rdata", rdata, e.data);
                        checkOutput("rvalid_latency", 32'(edgeCount), 32'(e.due));
                    end
                end else if (expQ.size() > 0 && expQ[0].due <= edgeCount) begin
                    checkOutput("rvalid", 32'h0, 32'h1);
                    void'(expQ.pop_front());
                end
                checkOutput("console_valid", {31'b0, consoleValid}, {31'b0, fifoQ.size() > 0});
                if (fifoQ.size() > 0) checkOutput("console_data", {24'b0, consoleData}, {24'b0, fifoQ[0]});
                checkOutput("finish", {31'b0, finish}, {31'b0, finishM});
                checkOutput("exit_code", exitCode, exitM);
            end
        end
    end

    // Directed scenarios, mid-burst reset, then random traffic.
    initial begin
        bit g;
        logic [1:0] off;
        checks       = 0;
        passes       = 0;
        inReset      = 1'b1;
        rst          = 1'b1;
        req          = 1'b0;
        addr         = 32'h0;
        we           = 1'b0;
        be           = 4'h0;
        wdata        = 32'h0;
        consoleReady = 1'b0;
        resetModel();
        repeat (3) @(negedge clk);
        checkResetOutputs("reset");
        rst     = 1'b0;
        inReset = 1'b0;

        $display("[TB] status read after reset");
        applyStimulus(BASE + 32'h8, 1'b0, 4'hF, 32'h0, 4, 1'b0);
        idle(2);

        $display("[TB] console bytes");
        applyStimulus(BASE, 1'b1, 4'h1, 32'h48, 4, 1'b0);
        applyStimulus(BASE, 1'b1, 4'h1, 32'h69, 4, 1'b0);
        consoleReady = 1'b1;
        idle(4);

        $display("[TB] fifo full and back-pressure");
        consoleReady = 1'b0;
        for (int i = 0; i < DEPTH; i++) applyStimulus(BASE, 1'b1, 4'hF, 32'hA0 + i, 4, 1'b0);
        applyStimulus(BASE + 32'h8, 1'b0, 4'hF, 32'h0, 4, 1'b0);
        applyStimulus(BASE, 1'b0, 4'hF, 32'h0, 4, 1'b0);
        req = 1'b1; addr = BASE; we = 1'b1; be = 4'h1; wdata = 32'hB9;
        runCycle(g);
        runCycle(g);
        consoleReady = 1'b1;
        runCycle(g);
        consoleReady = 1'b0;
        runCycle(g);
        req = 1'b0;
        consoleReady = 1'b1;
        idle(12);

        $display("[TB] finish word");
        applyStimulus(BASE + 32'hC, 1'b1, 4'hF, 32'h0, 4, 1'b0);
        applyStimulus(BASE + 32'hC, 1'b1, 4'hF, 32'h7, 4, 1'b0);
        applyStimulus(BASE + 32'hC, 1'b0, 4'hF, 32'h0, 4, 1'b0);
        idle(2);

        $display("[TB] cycle counter wrap and out-of-window request");
        applyStimulus(BASE + 32'h4, 1'b1, 4'hF, 32'hFFFF_FFFE, 4, 1'b0);
        idle(2);
        applyStimulus(BASE + 32'h4, 1'b0, 4'hF, 32'h0, 4, 1'b0);
        req = 1'b1; addr = 32'h003F_FFEC; we = 1'b0; be = 4'hF;
        runCycle(g);
        runCycle(g);
        idle(2);

        $display("[TB] reset with response pending");
        consoleReady = 1'b0;
        applyStimulus(BASE, 1'b1, 4'h1, 32'h55, 4, 1'b0);
        applyStimulus(BASE, 1'b1, 4'h1, 32'h66, 4, 1'b0);
        req = 1'b1; addr = BASE + 32'h8; we = 1'b0; be = 4'hF;
        #1;
        @(posedge clk);
        #2;
        inReset = 1'b1;
        rst     = 1'b1;
        req     = 1'b0;
        #1;
        checkResetOutputs("async_reset");
        resetModel();
        repeat (2) @(negedge clk);
        rst     = 1'b0;
        inReset = 1'b0;
        applyStimulus(BASE + 32'h8, 1'b0, 4'hF, 32'h0, 4, 1'b0);
        applyStimulus(BASE + 32'h4, 1'b0, 4'hF, 32'h0, 4, 1'b0);
        idle(2);

        $display("[TB] random traffic");
        for (int i = 0; i < 300; i++) begin
            consoleReady = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) begin
                req   = 1'b1;
                addr  = ($urandom_range(0, 1) == 0) ? (BASE - 32'h10) : (BASE + 32'h10);
                addr  = addr + 32'($urandom_range(0, 3) * 4);
                we    = 1'($urandom_range(0, 1));
                be    = 4'($urandom_range(0, 15));
                wdata = $urandom;
                runCycle(g);
                req = 1'b0;
            end else begin
                off = 2'($urandom_range(0, 3));
                applyStimulus(BASE + {28'h0, off, 2'b00}, 1'($urandom_range(0, 1)),
                              ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(0, 15)),
                              $urandom, 64, 1'b1);
            end
            if ($urandom_range(0, 7) == 0) idle(1);
        end

        consoleReady = 1'b1;
        idle(12);
        checkOutput("scoreboard_drained", 32'(expQ.size()), 32'h0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
